// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - LEGv8 opcode constants, control encodings and opcode decoder
//
// Purpose: shared definitions for the decode stage. decode_ctrl() maps an
// 11-bit opcode to the control bundle, operand-select and immediate format.
// Ports: none (package).

package cpu_pkg;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  // Shorter opcodes: the remaining low opcode bits belong to the immediate.
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC   = 2'b10;

  localparam logic [1:0] ALU_SRC_REG = 2'b00;
  localparam logic [1:0] ALU_SRC_IMM = 2'b01;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_D    = 3'd1,
    IMM_I    = 3'd2,
    IMM_CB   = 3'd3,
    IMM_B    = 3'd4
  } imm_fmt_e;

  // Controls carried into the ID/EX register.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       b;
    logic       cbz;
    logic       cbnz;
    logic       illegal;
    logic [1:0] alu_op;
    logic [1:0] alu_src;
  } ex_ctrl_t;

  // Full decode result: EX controls plus decode-local selects.
  typedef struct packed {
    ex_ctrl_t ex;
    logic     reg2loc;
    imm_fmt_e imm_fmt;
  } dec_ctrl_t;

  function automatic dec_ctrl_t decode_ctrl(input logic [10:0] opcode);
    dec_ctrl_t c;
    c = '0;
    if (opcode == OP_LDUR) begin
      c.ex.reg_write  = 1'b1;
      c.ex.mem_read   = 1'b1;
      c.ex.mem_to_reg = 1'b1;
      c.ex.alu_op     = ALU_OP_ADD;
      c.ex.alu_src    = ALU_SRC_IMM;
      c.imm_fmt       = IMM_D;
    end else if (opcode == OP_STUR) begin
      c.ex.mem_write  = 1'b1;
      c.ex.alu_op     = ALU_OP_ADD;
      c.ex.alu_src    = ALU_SRC_IMM;
      c.reg2loc       = 1'b1;
      c.imm_fmt       = IMM_D;
    end else if (opcode == OP_ADD || opcode == OP_SUB ||
                 opcode == OP_AND || opcode == OP_ORR) begin
      c.ex.reg_write  = 1'b1;
      c.ex.alu_op     = ALU_OP_FUNC;
      c.ex.alu_src    = ALU_SRC_REG;
    end else if (opcode[10:1] == OP_ADDI) begin
      c.ex.reg_write  = 1'b1;
      c.ex.alu_op     = ALU_OP_ADD;
      c.ex.alu_src    = ALU_SRC_IMM;
      c.imm_fmt       = IMM_I;
    end else if (opcode[10:1] == OP_SUBI) begin
      // Subtraction is not plain add, so EX uses its function path.
      c.ex.reg_write  = 1'b1;
      c.ex.alu_op     = ALU_OP_FUNC;
      c.ex.alu_src    = ALU_SRC_IMM;
      c.imm_fmt       = IMM_I;
    end else if (opcode[10:3] == OP_CBZ) begin
      c.ex.cbz        = 1'b1;
      c.ex.alu_op     = ALU_OP_PASS_B;
      c.reg2loc       = 1'b1;
      c.imm_fmt       = IMM_CB;
    end else if (opcode[10:3] == OP_CBNZ) begin
      c.ex.cbnz       = 1'b1;
      c.ex.alu_op     = ALU_OP_PASS_B;
      c.reg2loc       = 1'b1;
      c.imm_fmt       = IMM_CB;
    end else if (opcode[10:5] == OP_B) begin
      c.ex.b          = 1'b1;
      c.imm_fmt       = IMM_B;
    end else begin
      c.ex.illegal    = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file, 2 read ports, 1 write port
//
// Purpose: NUM_REGS x DATA_W registers; index NUM_REGS-1 (XZR) reads zero
// and ignores writes. Optional macro DECODE_BYPASS_EN makes reads
// write-through (a read of the index being written returns wd_i).
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset (clears all)
//   ra1_i/rd1_o           read port 1 index / data (combinational)
//   ra2_i/rd2_o           read port 2 index / data (combinational)
//   we_i, wa_i, wd_i      write enable, index, data (on rising edge)

module reg_file
  #(parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int RA_W     = $clog2(NUM_REGS))
  (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [RA_W-1:0]   ra1_i,
  output logic [DATA_W-1:0] rd1_o,
  input  logic [RA_W-1:0]   ra2_i,
  output logic [DATA_W-1:0] rd2_o,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i
  );

  localparam logic [RA_W-1:0] XZR = RA_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != XZR) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  always_comb begin
    rd1_o = regs_q[ra1_i];
`ifdef DECODE_BYPASS_EN
    if (we_i && wa_i == ra1_i) rd1_o = wd_i;
`endif
    if (ra1_i == XZR) rd1_o = '0;
  end

  always_comb begin
    rd2_o = regs_q[ra2_i];
`ifdef DECODE_BYPASS_EN
    if (we_i && wa_i == ra2_i) rd2_o = wd_i;
`endif
    if (ra2_i == XZR) rd2_o = '0;
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - LEGv8 instruction decode stage with ID/EX register
//
// Purpose: decodes if_instr, reads operands from reg_file, extends the
// immediate and registers everything into ID/EX behind a valid/ready
// handshake. Inserts load-use bubbles; flush kills ID/EX and the offer.
// Optional macro DECODE_BYPASS_EN: write-through register file; when
// undefined, a same-cycle writeback to a source register also stalls.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_valid, if_instr, if_pc       upstream offer; id_ready accepts it
//   flush, ex_ready                 kill / downstream consume
//   wb_we, wb_rd, wb_data           register write port
//   id_valid, id_pc, id_data1, id_data2, id_imm, id_rd   ID/EX payload
//   id_reg_write .. id_illegal, id_alu_op, id_alu_src    ID/EX controls

module decode_stage
  import cpu_pkg::*;
  #(parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int RA_W     = $clog2(NUM_REGS))
  (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [DATA_W-1:0] if_pc,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              wb_we,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_data1,
  output logic [DATA_W-1:0] id_data2,
  output logic [DATA_W-1:0] id_imm,
  output logic [RA_W-1:0]   id_rd,
  output logic              id_reg_write,
  output logic              id_mem_read,
  output logic              id_mem_write,
  output logic              id_mem_to_reg,
  output logic              id_b,
  output logic              id_cbz,
  output logic              id_cbnz,
  output logic              id_illegal,
  output logic [1:0]        id_alu_op,
  output logic [1:0]        id_alu_src
  );

  localparam logic [RA_W-1:0] XZR = RA_W'(NUM_REGS - 1);

  dec_ctrl_t         dec;
  logic [RA_W-1:0]   rn, rm_sel, rd;
  logic [DATA_W-1:0] rdata1, rdata2, imm;
  logic              ld_hazard, wb_hazard, accept;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, data1_q, data1_d, data2_q, data2_d, imm_q, imm_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  ex_ctrl_t          ctrl_q, ctrl_d;

  assign dec    = decode_ctrl(if_instr[31:21]);
  assign rn     = RA_W'(if_instr[9:5]);
  // Stores and compare-branches read Rt (in the Rd field) on port 2.
  assign rm_sel = dec.reg2loc ? RA_W'(if_instr[4:0]) : RA_W'(if_instr[20:16]);
  assign rd     = RA_W'(if_instr[4:0]);

  reg_file #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RA_W(RA_W)) u_reg_file (
    .clk_i   (clk),
    .reset_i (reset),
    .ra1_i   (rn),
    .rd1_o   (rdata1),
    .ra2_i   (rm_sel),
    .rd2_o   (rdata2),
    .we_i    (wb_we),
    .wa_i    (wb_rd),
    .wd_i    (wb_data)
  );

  always_comb begin
    imm = '0;
    case (dec.imm_fmt)
      IMM_D:   imm = {{(DATA_W-9){if_instr[20]}}, if_instr[20:12]};
      IMM_I:   imm = {{(DATA_W-12){1'b0}}, if_instr[21:10]};
      IMM_CB:  imm = {{(DATA_W-21){if_instr[23]}}, if_instr[23:5], 2'b00};
      IMM_B:   imm = {{(DATA_W-28){if_instr[25]}}, if_instr[25:0], 2'b00};
      default: imm = '0;
    endcase
  end

  // A load in ID/EX has not produced its data yet; XZR never carries data.
  assign ld_hazard = valid_q && ctrl_q.mem_read && (rd_q != XZR) &&
                     ((rd_q == rn) || (rd_q == rm_sel));

`ifdef DECODE_BYPASS_EN
  assign wb_hazard = 1'b0;
`else
  // Without write-through the read would see the pre-write value.
  assign wb_hazard = wb_we && (wb_rd != XZR) &&
                     ((wb_rd == rn) || (wb_rd == rm_sel));
`endif

  assign id_ready = flush || (!(ld_hazard || wb_hazard) && (!valid_q || ex_ready));
  assign accept   = if_valid && id_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pc_d    = if_pc;
      data1_d = rdata1;
      data2_d = rdata2;
      imm_d   = imm;
      rd_d    = rd;
      ctrl_d  = dec.ex;
    end else if (ex_ready) begin
      // Consumed with nothing new (or a hazard): leave a bubble.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign id_valid      = valid_q;
  assign id_pc         = pc_q;
  assign id_data1      = data1_q;
  assign id_data2      = data2_q;
  assign id_imm        = imm_q;
  assign id_rd         = rd_q;
  assign id_reg_write  = ctrl_q.reg_write;
  assign id_mem_read   = ctrl_q.mem_read;
  assign id_mem_write  = ctrl_q.mem_write;
  assign id_mem_to_reg = ctrl_q.mem_to_reg;
  assign id_b          = ctrl_q.b;
  assign id_cbz        = ctrl_q.cbz;
  assign id_cbnz       = ctrl_q.cbnz;
  assign id_illegal    = ctrl_q.illegal;
  assign id_alu_op     = ctrl_q.alu_op;
  assign id_alu_src    = ctrl_q.alu_src;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage

module tb_decode_stage;

  localparam int DATA_W = 64;
  localparam int NUM_REGS = 32;
  localparam int RA_W = 5;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_LDUR = 0, K_STUR = 1, K_ADD = 2, K_SUB = 3, K_AND = 4, K_ORR = 5,
                 K_ADDI = 6, K_SUBI = 7, K_CBZ = 8, K_CBNZ = 9, K_B = 10, K_ILL = 11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [63:0] if_pc = '0;
  logic id_ready;
  logic flush = 1'b0;
  logic ex_ready = 1'b0;
  logic wb_we = 1'b0;
  logic [4:0] wb_rd = '0;
  logic [63:0] wb_data = '0;
  logic id_valid;
  logic [63:0] id_pc, id_data1, id_data2, id_imm;
  logic [4:0] id_rd;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic id_b, id_cbz, id_cbnz, id_illegal;
  logic [1:0] id_alu_op, id_alu_src;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_data1(id_data1), .id_data2(id_data2),
    .id_imm(id_imm), .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_b(id_b),
    .id_cbz(id_cbz), .id_cbnz(id_cbnz), .id_illegal(id_illegal),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src)
  );

  typedef struct {
    logic [63:0] pc, d1, d2, imm;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    bit          mem_read;
  } exp_t;

  exp_t exp_q[$];
  logic [63:0] regs [32];
  int n_checks = 0;
  int n_fail = 0;
  bit rst_cmd = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int classify(input logic [31:0] ins);
    case (ins[31:21])
      11'b11111000010: return K_LDUR;
      11'b11111000000: return K_STUR;
      11'b10001011000: return K_ADD;
      11'b11001011000: return K_SUB;
      11'b10001010000: return K_AND;
      11'b10101010000: return K_ORR;
      default: ;
    endcase
    if ((ins >> 22) == 32'b1001000100) return K_ADDI;
    if ((ins >> 22) == 32'b1101000100) return K_SUBI;
    if ((ins >> 24) == 32'b10110100) return K_CBZ;
    if ((ins >> 24) == 32'b10110101) return K_CBNZ;
    if ((ins >> 26) == 32'b000101) return K_B;
    return K_ILL;
  endfunction

  // {reg_write, mem_read, mem_write, mem_to_reg, b, cbz, cbnz, illegal, alu_op, alu_src}
  function automatic logic [11:0] ctrl_of(input int k);
    case (k)
      K_LDUR:                   return 12'b1101_0000_0001;
      K_STUR:                   return 12'b0010_0000_0001;
      K_ADD, K_SUB, K_AND, K_ORR: return 12'b1000_0000_1000;
      K_ADDI:                   return 12'b1000_0000_0001;
      K_SUBI:                   return 12'b1000_0000_1001;
      K_CBZ:                    return 12'b0000_0100_0100;
      K_CBNZ:                   return 12'b0000_0010_0100;
      K_B:                      return 12'b0000_1000_0000;
      default:                  return 12'b0000_0001_0000;
    endcase
  endfunction

  function automatic bit uses_rt(input int k);
    return (k == K_STUR) || (k == K_CBZ) || (k == K_CBNZ);
  endfunction

  function automatic logic [63:0] imm_of(input int k, input logic [31:0] ins);
    logic signed [8:0]  s9;
    logic signed [18:0] s19;
    logic signed [25:0] s26;
    longint v;
    v = 0;
    case (k)
      K_LDUR, K_STUR: begin s9 = ins[20:12]; v = s9; end
      K_ADDI, K_SUBI: v = longint'(ins[21:10]);
      K_CBZ, K_CBNZ:  begin s19 = ins[23:5]; v = s19; v = v * 4; end
      K_B:            begin s26 = ins[25:0]; v = s26; v = v * 4; end
      default:        v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic logic [63:0] rval(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    if (BYP && wb_we && wb_rd == idx) return wb_data;
    return regs[idx];
  endfunction

  function automatic exp_t build_exp(input logic [31:0] ins, input logic [63:0] pc);
    exp_t e;
    int k;
    k = classify(ins);
    e.pc = pc;
    e.d1 = rval(ins[9:5]);
    e.d2 = rval(uses_rt(k) ? ins[4:0] : ins[20:16]);
    e.imm = imm_of(k, ins);
    e.rd = ins[4:0];
    e.ctrl = ctrl_of(k);
    e.mem_read = (k == K_LDUR);
    return e;
  endfunction

  task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                      input bit exr, input bit fl, input bit we, input logic [4:0] wrd,
                      input logic [63:0] wd, output bit acc);
    @(posedge clk);
    #1;
    reset = rst_cmd; if_valid = v; if_instr = ins; if_pc = pc; ex_ready = exr;
    flush = fl; wb_we = we; wb_rd = wrd; wb_data = wd;
    @(negedge clk);
    #1;
    acc = if_valid && id_ready && !flush && !reset;
    if (acc) exp_q.push_back(build_exp(if_instr, if_pc));
    if (!reset && wb_we && wb_rd != 5'd31) regs[wb_rd] = wb_data;
  endtask

  task automatic idle(input bit exr);
    bit a;
    step(1'b0, 32'h0, 64'h0, exr, 1'b0, 1'b0, 5'd0, 64'h0, a);
  endtask

  // Offer one instruction until taken, with an optional writeback in the first cycle.
  task automatic offer(input logic [31:0] ins, input bit we, input logic [4:0] wrd,
                       input logic [63:0] wd);
    bit a;
    a = 1'b0;
    for (int k = 0; k < 8 && !a; k++)
      step(1'b1, ins, 64'h1000 + 64'(k), 1'b1, 1'b0, (k == 0) ? we : 1'b0, wrd, wd, a);
    chk("offer_accepted", 64'(a), 64'd1);
  endtask

  task automatic do_reset;
    rst_cmd = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("rst_valid", 64'(id_valid), 64'd0);
    chk("rst_pc", id_pc, 64'd0);
    chk("rst_data", id_data1 | id_data2, 64'd0);
    chk("rst_imm", id_imm, 64'd0);
    chk("rst_rd", 64'(id_rd), 64'd0);
    chk("rst_ctrl", 64'({id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_b,
                         id_cbz, id_cbnz, id_illegal, id_alu_op, id_alu_src}), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 32; i++) regs[i] = 64'd0;
    rst_cmd = 1'b0;
  endtask

  function automatic logic [31:0] mk(input int k, input logic [4:0] rd, input logic [4:0] rn,
                                     input logic [4:0] rm, input logic [31:0] r);
    case (k)
      K_LDUR: return {11'b11111000010, r[8:0], 2'b00, rn, rd};
      K_STUR: return {11'b11111000000, r[8:0], 2'b00, rn, rd};
      K_ADD:  return {11'b10001011000, rm, 6'd0, rn, rd};
      K_SUB:  return {11'b11001011000, rm, 6'd0, rn, rd};
      K_AND:  return {11'b10001010000, rm, 6'd0, rn, rd};
      K_ORR:  return {11'b10101010000, rm, 6'd0, rn, rd};
      K_ADDI: return {10'b1001000100, r[11:0], rn, rd};
      K_SUBI: return {10'b1101000100, r[11:0], rn, rd};
      K_CBZ:  return {8'b10110100, r[18:0], rd};
      K_CBNZ: return {8'b10110101, r[18:0], rd};
      K_B:    return {6'b000101, r[25:0]};
      default: return {r[31] ? 11'b01111111111 : 11'b00000000000, r[20:0]};
    endcase
  endfunction

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  // Monitor: ID/EX model is the queue head; checks payload and handshake.
  always @(negedge clk) begin
    exp_t h;
    bit hv, ldh, wbh, er;
    int k;
    logic [4:0] rn, r2;
    if (!reset) begin
      hv = exp_q.size() > 0;
      chk("id_valid", 64'(id_valid), 64'(hv));
      if (hv && id_valid) begin
        h = exp_q[0];
        chk("id_pc", id_pc, h.pc);
        chk("id_data1", id_data1, h.d1);
        chk("id_data2", id_data2, h.d2);
        chk("id_imm", id_imm, h.imm);
        chk("id_rd", 64'(id_rd), 64'(h.rd));
        chk("id_ctrl", 64'({id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_b,
                            id_cbz, id_cbnz, id_illegal, id_alu_op, id_alu_src}),
            64'(h.ctrl));
      end
      k = classify(if_instr);
      rn = if_instr[9:5];
      r2 = uses_rt(k) ? if_instr[4:0] : if_instr[20:16];
      ldh = hv && exp_q[0].mem_read && exp_q[0].rd != 5'd31 &&
            (exp_q[0].rd == rn || exp_q[0].rd == r2);
      wbh = !BYP && wb_we && wb_rd != 5'd31 && (wb_rd == rn || wb_rd == r2);
      er = flush || (!ldh && !wbh && (!hv || ex_ready));
      chk("id_ready", 64'(id_ready), 64'(er));
      if (hv && (ex_ready || flush)) void'(exp_q.pop_front());
    end
  end

  initial begin
    bit a, pend, fl, exr, we;
    logic [31:0] ins;
    logic [63:0] pc;

    do_reset();

    offer(32'h910016E1, 1'b0, 5'd0, 64'h0);
    idle(1'b1);

    offer(mk(K_ADD, 5'd3, 5'd2, 5'd2, 0), 1'b1, 5'd2, 64'hDEAD_BEEF);
    idle(1'b1);

    offer(mk(K_ADDI, 5'd1, 5'd31, 5'd0, 32'd77), 1'b0, 5'd0, 64'h0);
    offer(mk(K_LDUR, 5'd4, 5'd1, 5'd0, 32'd0), 1'b0, 5'd0, 64'h0);
    offer(mk(K_ADD, 5'd5, 5'd4, 5'd1, 0), 1'b0, 5'd0, 64'h0);
    idle(1'b1);

    offer(mk(K_CBZ, 5'd7, 5'd0, 5'd0, 32'h7FFFF), 1'b1, 5'd7, 64'h55);
    idle(1'b1);

    // Hold, then flush with a live offer.
    step(1'b1, mk(K_SUBI, 5'd2, 5'd3, 5'd0, 32'hABC), 64'h2000, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, a);
    for (int i = 0; i < 3; i++)
      step(1'b1, mk(K_ORR, 5'd6, 5'd2, 5'd3, 0), 64'h2004, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, a);
    step(1'b1, mk(K_ORR, 5'd6, 5'd2, 5'd3, 0), 64'h2004, 1'b0, 1'b1, 1'b0, 5'd0, 64'h0, a);
    idle(1'b0);

    offer(mk(K_ADD, 5'd6, 5'd31, 5'd31, 0), 1'b1, 5'd31, 64'h1234);
    offer(mk(K_STUR, 5'd31, 5'd31, 5'd0, 32'h1FF), 1'b0, 5'd0, 64'h0);
    offer(mk(K_ILL, 5'd1, 5'd2, 5'd3, 32'h0001_2345), 1'b0, 5'd0, 64'h0);
    offer(mk(K_B, 5'd0, 5'd0, 5'd0, 32'h0200_0000), 1'b0, 5'd0, 64'h0);
    idle(1'b1);

    pend = 1'b0;
    ins = 32'h0;
    pc = 64'h0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend) begin
        ins = mk($urandom_range(0, 11), pick_reg(), pick_reg(), pick_reg(), $urandom);
        pc = {$urandom, $urandom};
        pend = ($urandom_range(0, 9) < 8);
      end
      fl = ($urandom_range(0, 29) == 0);
      exr = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 3);
      step(pend, ins, pc, exr, fl, we, pick_reg(), {$urandom, $urandom}, a);
      if (a || fl) pend = 1'b0;
    end
    idle(1'b1);

    // Reset while ID/EX is held behind ex_ready=0.
    step(1'b1, mk(K_LDUR, 5'd2, 5'd3, 5'd0, 32'h1F0), 64'h3000, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, a);
    step(1'b1, mk(K_ADD, 5'd1, 5'd2, 5'd3, 0), 64'h3004, 1'b0, 1'b0, 1'b0, 5'd0, 64'h0, a);
    do_reset();
    offer(mk(K_ADD, 5'd1, 5'd2, 5'd3, 0), 1'b0, 5'd0, 64'h0);
    idle(1'b1);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
